// File: rtl/hamming_uart_pkg.sv
// Hamming UART link: shared constants and receive FSM encoding.
// Used by both the transmit and receive sides of the link.
package hamming_uart_pkg;

  localparam logic [31:0] DEF_FREQUENCY = 32'd50_000_000;
  localparam logic [31:0] DEF_SPEED     = 32'd9600;
  localparam int          DATA_BITS     = 8;
  localparam int          PACKAGE_BITS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, mid-bit sampling FSM.
// Strobes byte_valid_o / frame_err_o in the stop-sample cycle.
module uart_rx_byte
  import hamming_uart_pkg::*;
#(
  parameter logic [31:0] FREQUENCY = DEF_FREQUENCY,
  parameter logic [31:0] SPEED     = DEF_SPEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_valid_o,
  output logic                 frame_err_o,
  output logic                 idle_o
);

  localparam logic [31:0] DIVIDER = FREQUENCY / SPEED;
  localparam int TW = $clog2(DIVIDER + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(DIVIDER / 2);
  localparam logic [TW-1:0] T_LAST = TW'(DIVIDER - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 valid_d;
  logic                 ferr_d;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!armed_q) begin
          armed_d = rx_s;
        end else if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick_q == T_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == T_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == B_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == T_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
          // a low stop bit may be a break: rearm only once rx is high
          armed_d = rx_s;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_d;
  assign frame_err_o  = ferr_d;
  assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/hamming_uart_receiver.sv
// Hamming UART receiver: pairs bytes into 16-bit packages.
// Optional orphan-byte timeout under HAMMING_RX_TIMEOUT_EN.
module hamming_uart_receiver
  import hamming_uart_pkg::*;
#(
  parameter logic [31:0] FREQUENCY    = DEF_FREQUENCY,
  parameter logic [31:0] SPEED        = DEF_SPEED,
  parameter logic [31:0] TIMEOUT_BITS = 32'd20
) (
  input  logic                    CLK_i,
  input  logic                    reset,
  input  logic                    rx,
  output logic [PACKAGE_BITS-1:0] package_o,
  output logic                    package_valid_o,
  output logic                    frame_error_o,
  output logic                    busy_o
);

  logic [DATA_BITS-1:0]    rx_byte;
  logic                    byte_valid;
  logic                    frame_err;
  logic                    rx_idle;
  logic                    tmo_hit;
  logic                    pair_q, pair_d;
  logic [DATA_BITS-1:0]    high_q, high_d;
  logic [PACKAGE_BITS-1:0] pkg_q, pkg_d;
  logic                    pvalid_q, pvalid_d;
  logic                    ferr_q, ferr_d;

  uart_rx_byte #(
    .FREQUENCY(FREQUENCY),
    .SPEED    (SPEED)
  ) u_rx_byte (
    .clk         (CLK_i),
    .rst         (reset),
    .rx_i        (rx),
    .byte_o      (rx_byte),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err),
    .idle_o      (rx_idle)
  );

`ifdef HAMMING_RX_TIMEOUT_EN
  localparam logic [31:0] DIVIDER  = FREQUENCY / SPEED;
  localparam logic [31:0] TMO_LAST = TIMEOUT_BITS * DIVIDER - 1;

  logic [31:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (pair_q && rx_idle) begin
      if (tmo_q == TMO_LAST) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_i or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_BITS;
  assign tmo_hit    = 1'b0;
`endif

  // the four events are exclusive: byte strobes only leave STOP,
  // the timeout only fires while the byte FSM sits in IDLE
  always_comb begin
    pair_d   = pair_q;
    high_d   = high_q;
    pkg_d    = pkg_q;
    pvalid_d = 1'b0;
    ferr_d   = frame_err;
    unique case (1'b1)
      frame_err: begin
        pair_d = 1'b0;
      end
      byte_valid && pair_q: begin
        pkg_d    = {high_q, rx_byte};
        pvalid_d = 1'b1;
        pair_d   = 1'b0;
      end
      byte_valid && !pair_q: begin
        high_d = rx_byte;
        pair_d = 1'b1;
      end
      tmo_hit: begin
        pair_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_i or posedge reset) begin
    if (reset) begin
      pair_q   <= 1'b0;
      high_q   <= '0;
      pkg_q    <= '0;
      pvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pair_q   <= pair_d;
      high_q   <= high_d;
      pkg_q    <= pkg_d;
      pvalid_q <= pvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign package_o       = pkg_q;
  assign package_valid_o = pvalid_q;
  assign frame_error_o   = ferr_q;
  assign busy_o          = !rx_idle || pair_q;

endmodule
